// File: rtl/ps2_key_event_rx.sv
// Purpose : PS/2 keyboard receiver; filters the PS/2 clock, deframes bytes and folds E0/F0 prefixes into key events.
// Latency : key_valid/keycode/frame_err register one clk after the stop-bit falling edge is detected (edge detect <= FILTER_LEN+3 clk after pin falls).
// Backpressure: none; the PS/2 device cannot be stalled, so events are single-cycle pulses that must be consumed when seen.
//
// Ports:
//   clk        system clock (50 MHz nominal), rising edge
//   rst        synchronous active-high reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   key_code   scan code of the last emitted event
//   key_ext    last event was preceded by E0
//   key_break  last event was preceded by F0 (key release)
//   key_valid  one-cycle event strobe
//   keycode    {previous byte, latest byte} of the raw accepted byte stream
//   frame_err  one-cycle strobe on a rejected or timed-out frame
//
// Build option: define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits are not odd parity.
module ps2_key_event_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [7:0]  key_code,
   output logic        key_ext,
   output logic        key_break,
   output logic        key_valid,
   output logic [15:0] keycode,
   output logic        frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // synchronizers and clock filter; all idle-high after reset
   logic          clk_s1, clk_s2;
   logic          dat_s1, dat_s2;
   logic          filt_clk, filt_clk_d;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1     <= 1'b1;
         clk_s2     <= 1'b1;
         dat_s1     <= 1'b1;
         dat_s2     <= 1'b1;
         filt_clk   <= 1'b1;
         filt_clk_d <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_s1     <= ps2_clk;
         clk_s2     <= clk_s1;
         dat_s1     <= ps2_data;
         dat_s2     <= dat_s1;
         filt_clk_d <= filt_clk;
         // count consecutive samples that disagree with the filtered level;
         // any agreeing sample restarts the run, so short glitches vanish
         if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = filt_clk_d & ~filt_clk;

   // frame state
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_bit;
   logic          ext_pend, brk_pend;
   logic [TW-1:0] tcnt;
   logic          par_ok;

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ^{shift, par_bit};
`else
   // parity bit is still captured, it just never gates acceptance
   assign par_ok = par_bit | ~par_bit;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift     <= '0;
         par_bit   <= 1'b0;
         ext_pend  <= 1'b0;
         brk_pend  <= 1'b0;
         tcnt      <= '0;
         key_code  <= '0;
         key_ext   <= 1'b0;
         key_break <= 1'b0;
         key_valid <= 1'b0;
         keycode   <= '0;
         frame_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            tcnt <= '0;
            case (state)
               IDLE: begin
                  // a sampled 1 here is line noise, not a start bit
                  if (!dat_s2) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shift   <= {dat_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_bit <= dat_s2;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (dat_s2 && par_ok) begin
                     keycode <= {keycode[7:0], shift};
                     if (shift == 8'hE0) begin
                        ext_pend <= 1'b1;
                     end else if (shift == 8'hF0) begin
                        brk_pend <= 1'b1;
                     end else begin
                        key_code  <= shift;
                        key_ext   <= ext_pend;
                        key_break <= brk_pend;
                        key_valid <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     ext_pend  <= 1'b0;
                     brk_pend  <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            // a stalled device abandons the frame and any pending prefix
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state     <= IDLE;
               tcnt      <= '0;
               frame_err <= 1'b1;
               ext_pend  <= 1'b0;
               brk_pend  <= 1'b0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Purpose : directed bench for ps2_key_event_rx with an expected-event scoreboard.
// Latency : events are matched whenever the DUT strobes key_valid or frame_err.
// Backpressure: none; the bench drives the PS/2 pins at a fixed bit rate.
module tb_ps2_key_event_rx;

   localparam int HALF    = 20;    // clk cycles per PS/2 clock half-period
   localparam int TIMEOUT = 2000;  // shortened so the stall case stays cheap

   logic        clk;
   logic        rst;
   logic        ps2_clk;
   logic        ps2_data;
   logic [7:0]  key_code;
   logic        key_ext;
   logic        key_break;
   logic        key_valid;
   logic [15:0] keycode;
   logic        frame_err;

   ps2_key_event_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_break (key_break),
      .key_valid (key_valid),
      .keycode   (keycode),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [7:0]  code;
      logic        ext;
      logic        brk;
      logic [15:0] kc;
   } exp_t;

   exp_t sb[$];
   int vectors = 0;
   int miscompares = 0;

   // reference state
   logic        m_ext = 1'b0;
   logic        m_brk = 1'b0;
   logic [15:0] m_kc  = 16'h0000;

   // event checker
   always @(negedge clk) begin
      if (key_valid || frame_err) begin
         exp_t e;
         vectors++;
         assert (!(key_valid && frame_err)) else begin
            miscompares++;
            $error("FAIL both_strobes key_valid=%b frame_err=%b expected not both", key_valid, frame_err);
         end
         vectors++;
         assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_event key_valid=%b frame_err=%b code=%h expected no event", key_valid, frame_err, key_code);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            assert (frame_err === e.err) else begin
               miscompares++;
               $error("FAIL event_kind frame_err=%b expected %b", frame_err, e.err);
            end
            if (!e.err) begin
               vectors++;
               assert ({key_code, key_ext, key_break} === {e.code, e.ext, e.brk}) else begin
                  miscompares++;
                  $error("FAIL key_event code/ext/brk=%h/%b/%b expected %h/%b/%b",
                         key_code, key_ext, key_break, e.code, e.ext, e.brk);
               end
               vectors++;
               assert (keycode === e.kc) else begin
                  miscompares++;
                  $error("FAIL keycode_at_event got %h expected %h", keycode, e.kc);
               end
            end
         end
      end
   end

   // watchdog
   initial begin
      #1_200_000;
      $display("FAIL watchdog simulation did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(posedge clk);
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      logic par;
      par = bad_par ? ^b : ~^b;
      return {~bad_stop, par, b, 1'b0};
   endfunction

   // predicts the outcome of one full frame, then transmits it
   task automatic put_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      bit ok;
      ok = !bad_stop;
`ifdef PS2_PARITY_CHECK_EN
      ok = ok && !bad_par;
`endif
      if (ok) begin
         m_kc = {m_kc[7:0], b};
         if (b == 8'hE0) m_ext = 1'b1;
         else if (b == 8'hF0) m_brk = 1'b1;
         else begin
            sb.push_back('{err: 1'b0, code: b, ext: m_ext, brk: m_brk, kc: m_kc});
            m_ext = 1'b0;
            m_brk = 1'b0;
         end
      end else begin
         sb.push_back('{err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0, kc: m_kc});
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
      send_bits(mk_frame(b, bad_par, bad_stop), 11);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      vectors++;
      assert (sb.size() == 0) else begin
         miscompares++;
         $error("FAIL drain_%s pending=%0d expected 0", tag, sb.size());
      end
   endtask

   task automatic check_zero(input string tag);
      @(negedge clk);
      vectors++;
      assert ({key_code, key_ext, key_break, key_valid, keycode, frame_err} === 28'h0) else begin
         miscompares++;
         $error("FAIL %s code=%h ext=%b brk=%b vld=%b keycode=%h err=%b expected all zero",
                tag, key_code, key_ext, key_break, key_valid, keycode, frame_err);
      end
   endtask

   initial begin
      rst      = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      check_zero("reset_state");
      @(posedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);

      // plain make code
      put_byte(8'h1C, 0, 0);
      wait_drain("make_1c");

      // release: F0 then 1C
      put_byte(8'hF0, 0, 0);
      wait_drain("f0");
      @(negedge clk);
      vectors++;
      assert (keycode === 16'h1CF0) else begin
         miscompares++;
         $error("FAIL keycode_after_f0 got %h expected 1cf0", keycode);
      end
      put_byte(8'h1C, 0, 0);
      wait_drain("break_1c");

      // extended release, then plain key
      put_byte(8'hE0, 0, 0);
      put_byte(8'hF0, 0, 0);
      put_byte(8'h6B, 0, 0);
      put_byte(8'h74, 0, 0);
      wait_drain("ext_break");

      // prefix order swapped and repeated
      put_byte(8'hF0, 0, 0);
      put_byte(8'hE0, 0, 0);
      put_byte(8'hE0, 0, 0);
      put_byte(8'h12, 0, 0);
      put_byte(8'hE1, 0, 0);
      wait_drain("prefix_order");

      // wrong parity: rejected only when parity checking is built in
      put_byte(8'h1C, 1, 0);
      wait_drain("bad_parity");

      // bad stop bit clears a pending prefix
      put_byte(8'hE0, 0, 0);
      put_byte(8'h33, 0, 1);
      put_byte(8'h1C, 0, 0);
      wait_drain("bad_stop");

      // stall after 4 data bits, with a pending prefix
      put_byte(8'hE0, 0, 0);
      sb.push_back('{err: 1'b1, code: 8'h00, ext: 1'b0, brk: 1'b0, kc: m_kc});
      m_ext = 1'b0;
      m_brk = 1'b0;
      send_bits(mk_frame(8'h55, 0, 0), 5);
      repeat (TIMEOUT + 50) @(posedge clk);
      wait_drain("timeout");
      put_byte(8'h29, 0, 0);
      wait_drain("after_timeout");

      // 3-cycle glitch on the clock while data looks like a start bit
      ps2_data = 1'b0;
      repeat (5) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (40) @(posedge clk);
      ps2_data = 1'b1;
      repeat (10) @(posedge clk);
      put_byte(8'h1C, 0, 0);
      wait_drain("glitch");

      // reset mid-frame after bit 5, with a pending prefix
      put_byte(8'hE0, 0, 0);
      send_bits(mk_frame(8'hA5, 0, 0), 6);
      rst = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_kc  = 16'h0000;
      repeat (3) @(posedge clk);
      check_zero("reset_midframe");
      @(posedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      check_zero("after_reset");
      put_byte(8'h5A, 0, 0);
      wait_drain("post_reset");

      repeat (20) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_rx.md
PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

Interface
REQ-001: FILTER_LEN, 8, number of consecutive equal synchronized samples required before the filtered PS2 clock changes level.
REQ-002: TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between falling edges inside a frame (2 ms at 50 MHz).
REQ-003: clk  input  1  system clock, 50 MHz nominal; all logic on rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
REQ-006: ps2_data  input  1  raw PS/2 data pin, asynchronous.
REQ-007: key_code  output  8  scan code of the last emitted key event.
REQ-008: key_ext  output  1  high when the last event was preceded by an E0 prefix.
REQ-009: key_break  output  1  high when the last event was preceded by an F0 prefix (release).
REQ-010: key_valid  output  1  one-cycle pulse; key_code, key_ext and key_break are valid in that cycle.
REQ-011: keycode  output  16  {previous byte, latest byte} of the raw byte stream, prefixes included.
REQ-012: frame_err  output  1  one-cycle pulse on a rejected frame.

Function
REQ-013: ps2_clk and ps2_data shall each pass through a 2-flop synchronizer before any use.
REQ-014: The filtered clock shall change level only after FILTER_LEN consecutive equal synchronized samples. A falling edge is a 1->0 transition of the filtered clock.
REQ-015: A falling edge shall be detected no later than FILTER_LEN+3 clk cycles after the raw pin falls.
REQ-016: Frame FSM states: IDLE, DATA, PARITY, STOP. Synchronized ps2_data is sampled only on a detected falling edge.
REQ-017: IDLE: a sampled 0 is the start bit and moves the FSM to DATA with bit count 0. A sampled 1 is ignored: stay in IDLE, no error.
REQ-018: DATA: bits are shifted in LSB first. After the 8th bit the FSM moves to PARITY.
REQ-019: PARITY: the bit is captured and the FSM moves to STOP.
REQ-020: STOP: the FSM returns to IDLE. The byte is accepted only if stop=1 and the parity condition of REQ-032 holds; otherwise frame_err pulses and the byte is discarded.
REQ-021: Outside IDLE, TIMEOUT_CYCLES clk cycles without a falling edge shall force IDLE, pulse frame_err and discard the partial byte. The counter clears on each falling edge.
REQ-022: Each accepted byte shall update keycode <= {keycode[7:0], byte} one cycle after the stop-bit edge detection.
REQ-023: Accepted byte E0 shall set the pending-ext flag. Byte F0 shall set the pending-break flag. Neither emits an event.
REQ-024: Any other accepted byte (E1 included) shall emit an event:
- key_code <= byte; key_ext <= ext flag; key_break <= break flag.
- key_valid pulses high for exactly one cycle, one cycle after stop-bit edge detection.
- Both pending flags clear in the same cycle.
REQ-025: Repeated E0 or F0 prefixes before a key byte shall leave their flags set; order is irrelevant (E0 F0 xx and F0 E0 xx are identical).
REQ-026: A rejected or timed-out frame shall clear both pending flags.
REQ-027: key_valid and frame_err shall never be high in the same cycle.

Reset
REQ-028: While rst=1:
- outputs key_code=00, key_ext=0, key_break=0, key_valid=0, keycode=0000, frame_err=0;
- FSM=IDLE, pending flags=0, timeout counter=0;
- synchronizers and filter set to 1 (idle bus).
REQ-029: Reset mid-frame shall discard the partial frame without a frame_err pulse.
REQ-030: The first falling edge accepted after reset release is treated as a potential start bit.

Configuration
REQ-031: Macro PS2_PARITY_CHECK_EN controls the parity check.
REQ-032: With PS2_PARITY_CHECK_EN defined: the 8 data bits plus the parity bit shall have odd total parity, else frame_err.
REQ-033: Without PS2_PARITY_CHECK_EN: the parity bit is captured and ignored; only the stop bit is checked.

Verification
REQ-034: Frame 0x1C, correct parity, stop=1 -> one key_valid with key_code=1C, ext=0, break=0; keycode=001C.
REQ-035: Bytes F0, 1C -> no event on F0, keycode=1CF0 after F0; then key_valid with code=1C, break=1, ext=0; keycode=F01C.
REQ-036: Bytes E0, F0, 6B -> single key_valid with code=6B, ext=1, break=1; next byte 74 -> code=74, ext=0, break=0.
REQ-037: 0x1C with wrong parity -> with PS2_PARITY_CHECK_EN: frame_err pulse, no key_valid, keycode unchanged; without it: key_valid, code=1C.
REQ-038: Stop after 4 data bits, idle 100000 cycles -> frame_err pulse, FSM IDLE; next valid frame 0x29 -> key_valid with code=29.
REQ-039: 3-cycle glitch on ps2_clk with FILTER_LEN=8 -> no edge detected, no state change. rst asserted after bit 5 -> outputs zero, no frame_err.
